// File: rtl/mio_pkg.sv
// Shared address map, CTRL bit positions, FSM and region encodings for the MIO responder.
package mio_pkg;

  localparam logic [31:0] LedAddr  = 32'hE000_0000;
  localparam logic [31:0] SwAddr   = 32'hE000_0004;
  localparam logic [31:0] CntAddr  = 32'hF000_0000;
  localparam logic [31:0] CmpAddr  = 32'hF000_0004;
  localparam logic [31:0] CtrlAddr = 32'hF000_0008;

  localparam int unsigned CtrlEnBit   = 0;
  localparam int unsigned CtrlPendBit = 1;
  localparam int unsigned CtrlIeBit   = 2;

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} mio_state_e;

  typedef enum logic [2:0] {
    RegRam, RegLed, RegSw, RegCnt, RegCmp, RegCtrl, RegNone
  } mio_region_e;

  // Address bits [1:0] never take part in the decode.
  function automatic mio_region_e mio_decode(input logic [31:0] addr,
                                             input int unsigned ram_aw);
    logic [31:0] word;
    word = {addr[31:2], 2'b00};
    if ((addr >> (ram_aw + 32'd2)) == 32'd0) return RegRam;
    if (word == LedAddr)  return RegLed;
    if (word == SwAddr)   return RegSw;
    if (word == CntAddr)  return RegCnt;
    if (word == CmpAddr)  return RegCmp;
    if (word == CtrlAddr) return RegCtrl;
    return RegNone;
  endfunction

endpackage

// File: rtl/mio_timer.sv
// Free-running timer: CNT/CMP/CTRL registers, compare match, sticky pending and registered INT.
module mio_timer import mio_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cnt_we_i,
  input  logic        cmp_we_i,
  input  logic        ctrl_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] cnt_o,
  output logic [31:0] cmp_o,
  output logic [31:0] ctrl_o,
  output logic        int_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        pend_q, pend_d;
  logic        int_q, int_d;
  logic        match;

  // Match looks at the pre-increment count, so each CNT==CMP value is seen once.
  assign match = en_q && (cnt_q == cmp_q);

  // Next-state: a CNT write beats the increment; a new match beats a W1C of pending.
  always_comb begin
    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    en_d   = en_q;
    ie_d   = ie_q;
    pend_d = pend_q;
    if (cnt_we_i) begin
      cnt_d = wdata_i;
    end else if (en_q) begin
      cnt_d = cnt_q + 32'd1;
    end
    if (cmp_we_i) cmp_d = wdata_i;
    if (ctrl_we_i) begin
      en_d = wdata_i[CtrlEnBit];
      ie_d = wdata_i[CtrlIeBit];
      if (wdata_i[CtrlPendBit]) pend_d = 1'b0;
    end
    if (match) pend_d = 1'b1;
    int_d = pend_d & ie_d;
  end

  // Timer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 32'd0;
      cmp_q  <= 32'hFFFF_FFFF;
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      en_q   <= en_d;
      ie_q   <= ie_d;
      pend_q <= pend_d;
      int_q  <= int_d;
    end
  end

  // CTRL read view.
  always_comb begin
    ctrl_o              = '0;
    ctrl_o[CtrlEnBit]   = en_q;
    ctrl_o[CtrlPendBit] = pend_q;
    ctrl_o[CtrlIeBit]   = ie_q;
  end

  assign cnt_o = cnt_q;
  assign cmp_o = cmp_q;
  assign int_o = int_q;

endmodule

// File: rtl/mio_bus_responder.sv
// MIO bus responder: decodes CPU requests to word RAM, LED/switch port or timer and
// returns a one-cycle ready pulse with load data.
module mio_bus_responder import mio_pkg::*; #(
  parameter int unsigned RAM_AW      = 10,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned IO_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_ready_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  input  logic [IO_W-1:0]   sw_i,
  output logic [IO_W-1:0]   led_o,
  output logic              timer_int_o
);

  localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

  mio_state_e        state_q, state_d;
  mio_region_e       region_q;
  logic              we_q;
  logic [RAM_AW-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wait_q, wait_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [IO_W-1:0]   led_q, led_d;
  logic [IO_W-1:0]   sw_meta_q, sw_sync_q;
  logic [31:0]       io_rdata;
  logic              io_wr;
  logic [31:0]       tmr_cnt, tmr_cmp, tmr_ctrl;

  assign io_wr = (state_q == StAccess) && we_q;

  mio_timer u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .cnt_we_i  (io_wr && (region_q == RegCnt)),
    .cmp_we_i  (io_wr && (region_q == RegCmp)),
    .ctrl_we_i (io_wr && (region_q == RegCtrl)),
    .wdata_i   (wdata_q),
    .cnt_o     (tmr_cnt),
    .cmp_o     (tmr_cmp),
    .ctrl_o    (tmr_ctrl),
    .int_o     (timer_int_o)
  );

  // I/O read mux; unmapped and RAM regions read as zero here.
  always_comb begin
    io_rdata = '0;
    case (region_q)
      RegLed:  io_rdata[IO_W-1:0] = led_q;
      RegSw:   io_rdata[IO_W-1:0] = sw_sync_q;
      RegCnt:  io_rdata = tmr_cnt;
      RegCmp:  io_rdata = tmr_cmp;
      RegCtrl: io_rdata = tmr_ctrl;
      default: io_rdata = '0;
    endcase
  end

  // FSM next-state, wait counter, read-data capture and LED update.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    led_d   = led_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req_i) state_d = StAccess;
      end
      StAccess: begin
        wait_d = 4'd0;
        if (region_q == RegRam) begin
          state_d = StWait;
        end else begin
          state_d = StResp;
          if (!we_q) rdata_d = io_rdata;
          if (we_q && (region_q == RegLed)) led_d = wdata_q[IO_W-1:0];
        end
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          state_d = StResp;
          if (!we_q) rdata_d = ram_rdata_i;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request latch and I/O registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      region_q <= RegNone;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= 32'd0;
      wait_q   <= 4'd0;
      rdata_q  <= 32'd0;
      led_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
      if ((state_q == StIdle) && cpu_req_i) begin
        region_q <= mio_decode(cpu_addr_i, RAM_AW);
        we_q     <= cpu_we_i;
        waddr_q  <= cpu_addr_i[RAM_AW+1:2];
        wdata_q  <= cpu_wdata_i;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign cpu_ready_o = (state_q == StResp);
  assign cpu_rdata_o = rdata_q;
  assign ram_en_o    = (state_q == StAccess) && (region_q == RegRam);
  assign ram_we_o    = ram_en_o && we_q;
  assign ram_addr_o  = waddr_q;
  assign ram_wdata_o = wdata_q;
  assign led_o       = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: table of single accesses plus hand-written
// sequences for timer, back-to-back, unmapped and mid-access reset cases.
module tb_mio_bus_responder;

  localparam logic [31:0] Led  = 32'hE000_0000;
  localparam logic [31:0] Sw   = 32'hE000_0004;
  localparam logic [31:0] Cnt  = 32'hF000_0000;
  localparam logic [31:0] Cmp  = 32'hF000_0004;
  localparam logic [31:0] Ctrl = 32'hF000_0008;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WAIT_CYCLES=0
  logic        req_a = 1'b0, we_a = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0, rdata_a, ram_wdata_a, ram_rdata_a;
  logic        ready_a, ram_en_a, ram_we_a, int_a;
  logic [9:0]  ram_addr_a;
  logic [15:0] sw = '0, led_a;
  // DUT B: WAIT_CYCLES=2
  logic        req_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr_b = '0, wdata_b = '0, rdata_b, ram_wdata_b, ram_rdata_b;
  logic        ready_b, ram_en_b, ram_we_b, int_b;
  logic [9:0]  ram_addr_b;
  logic [15:0] led_b;

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(0), .IO_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cpu_req_i(req_a), .cpu_we_i(we_a), .cpu_addr_i(addr_a),
    .cpu_wdata_i(wdata_a), .cpu_rdata_o(rdata_a), .cpu_ready_o(ready_a), .ram_en_o(ram_en_a),
    .ram_we_o(ram_we_a), .ram_addr_o(ram_addr_a), .ram_wdata_o(ram_wdata_a),
    .ram_rdata_i(ram_rdata_a), .sw_i(sw), .led_o(led_a), .timer_int_o(int_a)
  );

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(2), .IO_W(16)) dut_w2 (
    .clk_i(clk), .rst_ni(rst_n), .cpu_req_i(req_b), .cpu_we_i(we_b), .cpu_addr_i(addr_b),
    .cpu_wdata_i(wdata_b), .cpu_rdata_o(rdata_b), .cpu_ready_o(ready_b), .ram_en_o(ram_en_b),
    .ram_we_o(ram_we_b), .ram_addr_o(ram_addr_b), .ram_wdata_o(ram_wdata_b),
    .ram_rdata_i(ram_rdata_b), .sw_i(sw), .led_o(led_b), .timer_int_o(int_b)
  );

  // Synchronous read-first RAM models with write-pulse bookkeeping.
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  int          we_cnt_a = 0, we_cnt_b = 0;
  logic [9:0]  we_addr_a = '0, we_addr_b = '0;

  always @(posedge clk) begin
    if (ram_en_a) begin
      if (ram_we_a) begin
        mem_a[ram_addr_a] <= ram_wdata_a;
        we_cnt_a          <= we_cnt_a + 1;
        we_addr_a         <= ram_addr_a;
      end
      ram_rdata_a <= mem_a[ram_addr_a];
    end
    if (ram_en_b) begin
      if (ram_we_b) begin
        mem_b[ram_addr_b] <= ram_wdata_b;
        we_cnt_b          <= we_cnt_b + 1;
        we_addr_b         <= ram_addr_b;
      end
      ram_rdata_b <= mem_b[ram_addr_b];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request on DUT A (sel=0) or B (sel=1); lat counts edges from the sample edge
  // to ready (-1 on timeout). Leaves the FSM back in IDLE with req low.
  task automatic access(input bit sel, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat);
    if (!sel) begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
    end else begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (sel ? ready_b : ready_a) begin
        lat = i;
        break;
      end
    end
    rd = sel ? rdata_b : rdata_a;
    req_a = 1'b0;
    req_b = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       name;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input string name, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit chk_rd,
                              input logic [31:0] exp_rd, input int exp_lat);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_lat = exp_lat;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    int          lat, n, cnt, we0;

    vecs.push_back(mk("ld ram 0x40",     0, 32'h0000_0040, 0, 1, 32'h1234_5678, 3));
    vecs.push_back(mk("st led",          1, Led, 32'hFFFF_ABCD, 0, 0, 2));
    vecs.push_back(mk("ld led",          0, Led, 0, 1, 32'h0000_ABCD, 2));
    vecs.push_back(mk("ld sw",           0, Sw, 0, 1, 32'h0000_00F0, 2));
    vecs.push_back(mk("st ram top",      1, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 0, 3));
    vecs.push_back(mk("ld ram top",      0, 32'h0000_0FFC, 0, 1, 32'hCAFE_F00D, 3));
    vecs.push_back(mk("ld ram 0x40 b",   0, 32'h0000_0042, 0, 1, 32'h1234_5678, 3));
    vecs.push_back(mk("ld unmapped 8e7", 0, 32'h8000_0000, 0, 1, 32'h0000_0000, 2));
    vecs.push_back(mk("st cmp",          1, Cmp, 32'h0000_0005, 0, 0, 2));
    vecs.push_back(mk("ld cmp",          0, Cmp, 0, 1, 32'h0000_0005, 2));
    vecs.push_back(mk("ld past ram",     0, 32'h0000_1000, 0, 1, 32'h0000_0000, 2));
    vecs.push_back(mk("ld cmp again",    0, Cmp, 0, 1, 32'h0000_0005, 2));
    vecs.push_back(mk("ld unmapped io",  0, 32'hE000_0008, 0, 1, 32'h0000_0000, 2));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", 32'(ready_a), 32'd0);
    check("rst rdata", rdata_a, 32'd0);
    check("rst led", 32'(led_a), 32'd0);
    check("rst int", 32'(int_a), 32'd0);
    check("rst ram_en", 32'(ram_en_a), 32'd0);
    rst_n = 1'b1;
    sw = 16'h00F0;
    @(posedge clk); #1;

    // RAM store: exactly one write pulse at word 0x10
    we0 = we_cnt_a;
    access(0, 1, 32'h0000_0040, 32'h1234_5678, rd, lat);
    check("ram st lat", 32'(lat), 32'd3);
    check("ram st pulses", 32'(we_cnt_a - we0), 32'd1);
    check("ram st addr", 32'(we_addr_a), 32'h10);

    // Table of single accesses
    foreach (vecs[i]) begin
      access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      check({vecs[i].name, " lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      if (vecs[i].chk_rd) check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rd);
    end
    check("led after table", 32'(led_a), 32'h0000_ABCD);

    // Timer: CMP=5 already; CNT=0 then enable with ie. Ready is seen with CNT=0 and the
    // task returns one edge later with CNT=1, so INT rises 5 edges after that.
    access(0, 1, Cnt, 32'd0, rd, lat);
    access(0, 1, Ctrl, 32'h5, rd, lat);
    check("tmr int before match", 32'(int_a), 32'd0);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (int_a) begin
        n = i;
        break;
      end
    end
    check("tmr int delay", 32'(n), 32'd5);
    access(0, 0, Ctrl, 0, rd, lat);
    check("tmr ctrl pending", rd, 32'h7);
    access(0, 1, Ctrl, 32'h7, rd, lat);
    check("tmr int after w1c", 32'(int_a), 32'd0);
    access(0, 0, Ctrl, 0, rd, lat);
    check("tmr ctrl cleared", rd, 32'h5);
    // Write wins over increment, then wraps: FFFF_FFFF -> 0 -> 1 by the read cycle
    access(0, 1, Cnt, 32'hFFFF_FFFF, rd, lat);
    access(0, 0, Cnt, 0, rd, lat);
    check("tmr wrap", rd, 32'h1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (int_a) cnt++;
    end
    check("tmr rematch after wrap", 32'(cnt > 0), 32'd1);

    // Unmapped store changes nothing
    we0 = we_cnt_a;
    access(0, 1, 32'h8000_0000, 32'hDEAD_BEEF, rd, lat);
    check("unmapped st lat", 32'(lat), 32'd2);
    check("unmapped st ram", 32'(we_cnt_a - we0), 32'd0);
    check("unmapped st led", 32'(led_a), 32'h0000_ABCD);

    // Back-to-back stores with req held through ready
    req_a = 1'b1; we_a = 1'b1; addr_a = Led; wdata_a = 32'h1111;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready_a) begin
        n = i;
        break;
      end
    end
    check("b2b first lat", 32'(n), 32'd2);
    check("b2b first led", 32'(led_a), 32'h1111);
    wdata_a = 32'h2222;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ready_a) begin
        n = i;
        break;
      end
    end
    check("b2b second gap", 32'(n), 32'd3);
    check("b2b second led", 32'(led_a), 32'h2222);
    req_a = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready_a) cnt++;
    end
    check("idle after drop", 32'(cnt), 32'd0);
    access(0, 0, Led, 0, rd, lat);
    check("ld led after b2b", rd, 32'h2222);

    // WAIT_CYCLES=2 instance
    we0 = we_cnt_b;
    access(1, 1, 32'h0000_0040, 32'h1234_5678, rd, lat);
    check("w2 st lat", 32'(lat), 32'd5);
    check("w2 st pulses", 32'(we_cnt_b - we0), 32'd1);
    access(1, 0, 32'h0000_0040, 0, rd, lat);
    check("w2 ld lat", 32'(lat), 32'd5);
    check("w2 ld rdata", rd, 32'h1234_5678);

    // Reset while a RAM load sits in WAIT
    req_a = 1'b1; we_a = 1'b0; addr_a = 32'h0000_0040;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_a = 1'b0;
    #1;
    check("mid rst ready", 32'(ready_a), 32'd0);
    cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready_a) cnt++;
    end
    check("mid rst no ready", 32'(cnt), 32'd0);
    check("mid rst led", 32'(led_a), 32'd0);
    check("mid rst rdata", rdata_a, 32'd0);
    check("mid rst int", 32'(int_a), 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready_a) cnt++;
    end
    check("post rst no ready", 32'(cnt), 32'd0);
    access(0, 0, Cmp, 0, rd, lat);
    check("post rst cmp lat", 32'(lat), 32'd2);
    check("post rst cmp", rd, 32'hFFFF_FFFF);
    access(0, 0, Ctrl, 0, rd, lat);
    check("post rst ctrl", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
